// File: rtl/uart_pkg.sv
// Shared types, sample-point constants and parity helper for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_rx_state_t;

  localparam int DEF_OVERSAMPLING = 16;

  // Offsets of the three majority-vote samples around the bit centre M.
  localparam int SAMPLE_OFS_EARLY = -1;
  localparam int SAMPLE_OFS_MID   = 0;
  localparam int SAMPLE_OFS_LATE  = 1;

  // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for an asynchronous, idle-high serial input.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  // Reset to 1 so a line in its idle state never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '1;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_oversampled.sv
// UART receiver: oversampled majority-vote bit recovery, optional parity,
// valid/ready word output with framing, parity and overrun flags.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int OVERSAMPLING = DEF_OVERSAMPLING,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLING);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam int M     = OVERSAMPLING / 2;

  localparam logic [CNT_W-1:0] CNT_EARLY = CNT_W'(M + SAMPLE_OFS_EARLY);
  localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(M + SAMPLE_OFS_MID);
  localparam logic [CNT_W-1:0] CNT_LATE  = CNT_W'(M + SAMPLE_OFS_LATE);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVERSAMPLING - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic             PAR_ODD   = (PARITY_ODD != 0);

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  uart_rx_state_t       state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic [BIT_W-1:0]     bit_idx, bit_idx_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic                 par_rx, par_rx_next;
  logic                 s_early, s_early_next;
  logic                 s_mid, s_mid_next;
  logic                 rx_s;
  logic                 vote;
  logic                 decide;
  logic                 wrap;
  logic                 par_bad;
  logic                 load_req;
  logic                 frame_err_next;
  logic                 parity_err_next;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rx_s)
  );

  assign vote   = majority3(s_early, s_mid, rx_s);
  assign decide = (cnt == CNT_LATE);
  assign wrap   = (cnt == CNT_LAST);
  assign busy   = (state != IDLE);

  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    bit_idx_next    = bit_idx;
    shift_next      = shift;
    par_rx_next     = par_rx;
    s_early_next    = s_early;
    s_mid_next      = s_mid;
    par_bad         = 1'b0;
    load_req        = 1'b0;
    frame_err_next  = 1'b0;
    parity_err_next = 1'b0;

    if (baud_tick) begin
      cnt_next = wrap ? '0 : cnt + 1'b1;
      if (cnt == CNT_EARLY) s_early_next = rx_s;
      if (cnt == CNT_MID)   s_mid_next   = rx_s;

      case (state)
        IDLE: begin
          cnt_next = '0;
          if (!rx_s) state_next = START;
        end
        START: begin
          if (decide && vote) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else if (wrap) begin
            state_next   = DATA;
            bit_idx_next = '0;
          end
        end
        DATA: begin
          if (decide) shift_next[bit_idx] = vote;
          if (wrap) begin
            if (bit_idx == BIT_LAST) begin
              state_next = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_idx_next = bit_idx + 1'b1;
            end
          end
        end
        PARITY: begin
          if (decide) par_rx_next = vote;
          if (wrap)   state_next  = STOP;
        end
        // Leave at the vote rather than the wrap so a back-to-back start edge is not missed.
        STOP: begin
          if (decide) begin
            par_bad         = (PARITY_EN != 0) && (par_rx != parity_bit(8'(shift), PAR_ODD));
            frame_err_next  = !vote;
            parity_err_next = par_bad;
            load_req        = vote && !par_bad;
            state_next      = vote ? IDLE : BREAK;
            cnt_next        = '0;
          end
        end
        BREAK: begin
          cnt_next = '0;
          if (rx_s) state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      par_rx  <= 1'b0;
      s_early <= 1'b1;
      s_mid   <= 1'b1;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_idx_next;
      shift   <= shift_next;
      par_rx  <= par_rx_next;
      s_early <= s_early_next;
      s_mid   <= s_mid_next;
    end
  end

  // A new word may replace the held one only if the consumer takes the old one this clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= frame_err_next;
      parity_err  <= parity_err_next;
      overrun_err <= load_req && rx_valid && !rx_ready;
      if (load_req && (!rx_valid || rx_ready)) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: an 8N1 instance and an 8E1 instance fed by a
// 115200-baud serial driver, with an event scoreboard checked by a monitor.
`timescale 1ns/1ps
module tb_uart_rx_oversampled;

  localparam int DIV      = 27;
  localparam int BIT_CLKS = 16 * DIV;
  localparam int EV_ACC   = 0;
  localparam int EV_FERR  = 1;
  localparam int EV_PERR  = 2;
  localparam int EV_OVR   = 3;

  typedef struct {
    int         inst;
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rx_drv = 1'b1;
  logic       sel = 1'b0;
  logic       rx_ready = 1'b1;
  logic       rx_a, rx_p;
  logic [7:0] data_a, data_p;
  logic       valid_a, valid_p;
  logic       ferr_a, ferr_p, perr_a, perr_p, ovr_a, ovr_p, busy_a, busy_p;
  int         div = 0;
  int         checks = 0;
  int         errors = 0;
  int         valid_cnt = 0;
  ev_t        q[$];
  logic [15:0] fb;

  assign rx_a = sel ? 1'b1 : rx_drv;
  assign rx_p = sel ? rx_drv : 1'b1;

  uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMPLING(16), .PARITY_EN(0), .PARITY_ODD(0), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx(rx_a),
    .rx_data(data_a), .rx_valid(valid_a), .rx_ready(rx_ready),
    .frame_err(ferr_a), .parity_err(perr_a), .overrun_err(ovr_a), .busy(busy_a)
  );

  uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMPLING(16), .PARITY_EN(1), .PARITY_ODD(0), .SYNC_STAGES(2)) dut_p (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx(rx_p),
    .rx_data(data_p), .rx_valid(valid_p), .rx_ready(rx_ready),
    .frame_err(ferr_p), .parity_err(perr_p), .overrun_err(ovr_p), .busy(busy_p)
  );

  initial forever #10 clk = ~clk;

  // Divide-by-27 tick: 50 MHz / 27 / 16 is close to 115200 baud.
  initial forever begin
    @(posedge clk);
    if (div == DIV - 1) begin
      div       <= 0;
      baud_tick <= 1'b1;
    end else begin
      div       <= div + 1;
      baud_tick <= 1'b0;
    end
  end

  task automatic observe(input int inst, input int kind, input logic [7:0] data);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL event: got inst %0d kind %0d data %h, required no event", inst, kind, data);
    end else begin
      e = q.pop_front();
      if (e.inst != inst || e.kind != kind || (kind == EV_ACC && e.data != data)) begin
        errors++;
        $display("FAIL event: got inst %0d kind %0d data %h, required inst %0d kind %0d data %h",
                 inst, kind, data, e.inst, e.kind, e.data);
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (valid_a) valid_cnt++;
    if (ferr_a) observe(0, EV_FERR, 8'h00);
    if (perr_a) observe(0, EV_PERR, 8'h00);
    if (ovr_a)  observe(0, EV_OVR, 8'h00);
    if (valid_a && rx_ready) observe(0, EV_ACC, data_a);
    if (ferr_p) observe(1, EV_FERR, 8'h00);
    if (perr_p) observe(1, EV_PERR, 8'h00);
    if (ovr_p)  observe(1, EV_OVR, 8'h00);
    if (valid_p && rx_ready) observe(1, EV_ACC, data_p);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic push(input int inst, input int kind, input logic [7:0] data);
    ev_t e;
    e.inst = inst;
    e.kind = kind;
    e.data = data;
    q.push_back(e);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic logic [15:0] frame_bits(input logic [7:0] d, input bit with_par,
                                             input logic par, input logic stop);
    if (with_par) return {5'h1F, stop, par, d, 1'b0};
    return {6'h3F, stop, d, 1'b0};
  endfunction

  task automatic drive_bits(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx_drv = bits[i];
      wait_clks(BIT_CLKS);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit with_par, input logic par, input logic stop);
    drive_bits(frame_bits(d, with_par, par, stop), with_par ? 13 : 12);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 2 * BIT_CLKS) begin
      wait_clks(1);
      n++;
    end
    check(name, q.size(), 0);
  endtask

  initial begin
    // Reset state
    wait_clks(3);
    check("reset_valid", valid_a, 0);
    check("reset_data", data_a, 0);
    check("reset_busy", busy_a, 0);
    check("reset_errs", {ferr_a, perr_a, ovr_a}, 0);
    rst_n = 1'b1;
    wait_clks(2 * BIT_CLKS);

    // 8N1 0xA5, consumer always ready
    valid_cnt = 0;
    push(0, EV_ACC, 8'hA5);
    fb = frame_bits(8'hA5, 0, 1'b0, 1'b1);
    drive_bits(fb, 9);
    rx_drv = 1'b1;
    wait_clks(13 * DIV);
    check("a5_busy_after_midstop", busy_a, 0);
    wait_clks(BIT_CLKS);
    drain("a5_drain");
    check("a5_valid_cycles", valid_cnt, 1);

    // Glitch: 5 ticks low
    rx_drv = 1'b0;
    wait_clks(3 * DIV);
    check("glitch_busy_during", busy_a, 1);
    wait_clks(2 * DIV);
    rx_drv = 1'b1;
    wait_clks(2 * BIT_CLKS);
    check("glitch_idle", busy_a, 0);
    drain("glitch_drain");

    // 0x3C with stop low, line held low, then 0x55
    push(0, EV_FERR, 8'h00);
    fb = frame_bits(8'h3C, 0, 1'b0, 1'b0);
    drive_bits(fb, 10);
    wait_clks(20 * BIT_CLKS);
    check("break_busy", busy_a, 1);
    drain("break_drain");
    rx_drv = 1'b1;
    wait_clks(BIT_CLKS);
    check("break_release_idle", busy_a, 0);
    push(0, EV_ACC, 8'h55);
    send_frame(8'h55, 0, 1'b0, 1'b1);
    drain("after_break_55");

    // Even parity instance: 0x07 has odd weight, so parity bit must be 1
    sel = 1'b1;
    push(1, EV_PERR, 8'h00);
    send_frame(8'h07, 1, 1'b0, 1'b1);
    drain("parity_bad");
    push(1, EV_ACC, 8'h07);
    send_frame(8'h07, 1, 1'b1, 1'b1);
    drain("parity_good");
    check("parity_valid_clear", valid_p, 0);
    sel = 1'b0;
    wait_clks(BIT_CLKS);

    // Overrun: 0x11 held, 0x22 dropped
    rx_ready = 1'b0;
    send_frame(8'h11, 0, 1'b0, 1'b1);
    check("ovr_first_valid", valid_a, 1);
    check("ovr_first_data", data_a, 8'h11);
    push(0, EV_OVR, 8'h00);
    send_frame(8'h22, 0, 1'b0, 1'b1);
    drain("ovr_pulse");
    check("ovr_data_kept", data_a, 8'h11);
    check("ovr_valid_kept", valid_a, 1);
    push(0, EV_ACC, 8'h11);
    rx_ready = 1'b1;
    wait_clks(2);
    drain("ovr_pop");
    check("ovr_valid_dropped", valid_a, 0);
    check("ovr_data_after_pop", data_a, 8'h11);

    // Reset in the middle of data bit 4, then 0x81
    fb = frame_bits(8'h6B, 0, 1'b0, 1'b1);
    drive_bits(fb, 5);
    rx_drv = fb[5];
    wait_clks(BIT_CLKS / 2);
    check("midframe_busy", busy_a, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", valid_a, 0);
    check("rst_mid_data", data_a, 0);
    check("rst_mid_busy", busy_a, 0);
    check("rst_mid_errs", {ferr_a, perr_a, ovr_a}, 0);
    rx_drv = 1'b1;
    wait_clks(10);
    rst_n = 1'b1;
    wait_clks(2 * BIT_CLKS);
    check("rst_release_idle", busy_a, 0);
    push(0, EV_ACC, 8'h81);
    send_frame(8'h81, 0, 1'b0, 1'b1);
    drain("after_reset_81");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
